time_keeper_param: RTL and testbench
====================================

# time_keeper_param

Parametrised successor of the current-time block. Keeps a packed BCD minutes / binary hours / day-of-week time value in a single `Clk` domain. Advances it from an internal prescaler and supports:
- load with field validation (illegal values are rejected);
- carry-free set-mode minute and hour adjust;
- one-cycle minute-tick and day-rollover pulses for the alarm comparator and display logic.

## Interface
Parameters:
- `PRESCALE`, default 1: number of enabled `Clk` cycles per time step; must be ≥1. Prescaler width is `$clog2(PRESCALE)`, minimum 1.
- `DAYS`, default 7: days per week; legal range 1..8; day field is 3 bits.

Ports:
- `Clk`  in  1  the only clock; everything updates on the rising edge.
- `Clr`  in  1  reset, synchronous, active-high; highest priority.
- `EN_CT`  in  1  count enable; low freezes the prescaler and seconds (time held).
- `LD_CT`  in  1  load request for `CTI`.
- `CTI`  in  15  load value, bit layout:
  - [3:0] minutes ones, 0-9;
  - [6:4] minutes tens, 0-5;
  - [11:7] hours, 0-23;
  - [14:12] day, 0..DAYS-1.
- `Inc_Min`  in  1  set-mode minute +1 (mod 60), no hour carry.
- `Inc_Hr`  in  1  set-mode hour +1 (mod 24), no day carry.
- `CTO`  out  15  current time, same layout as `CTI`.
- `Sec_O`  out  6  seconds, 0-59; constant 0 unless `TKP_SECONDS_EN`.
- `Min_Tick`  out  1  one-cycle pulse when the minute advances by counting.
- `Day_Roll`  out  1  one-cycle pulse when the hours wrap 23→0 by counting.
- `Ld_Err`  out  1  one-cycle pulse when a load is rejected.

## Operation
- **Reset:** `Clr` high at an edge sets `CTO`, `Sec_O`, the prescaler, `Min_Tick`, `Day_Roll` and `Ld_Err` to 0. This overrides all other inputs.
- **Priority per edge:** `Clr` > `LD_CT` > `Inc_Min`/`Inc_Hr` > counting.
- **Load:**
  - Legal `CTI`: `CTO` ← `CTI`; prescaler ← 0; `Sec_O` ← 0.
  - Illegal `CTI` (any of ones>9, tens>5, hours>23, day≥DAYS): state unchanged; `Ld_Err` = 1 for one cycle.
  - No tick or pulse is generated on a load cycle.
- **Adjust:**
  - `Inc_Min`: minutes 59 → 00; hour unchanged.
  - `Inc_Hr`: hours 23 → 0; day unchanged.
  - Both asserted in one cycle: both apply.
  - Adjusts work regardless of `EN_CT`.
  - Adjusts never raise `Min_Tick` or `Day_Roll`.
  - On an adjust cycle the prescaler still counts and wraps if enabled, but a tick produced by that wrap is discarded.
- **Prescaler:**
  - With `EN_CT` high, counts 0..PRESCALE-1 and wraps.
  - The wrap cycle is a "step".
  - `PRESCALE`=1: every enabled cycle is a step.
- **Counting on a step:**
  - Minutes ones 9 → 0 carries into tens.
  - Tens 5 → 0 carries into hours.
  - Hours 23 → 0 carries into day.
  - Day DAYS-1 → 0.
- **Arithmetic:** all fields wrap modulo their range. The block never produces an illegal field value internally.

## Timing
- All outputs are registered.
- `LD_CT` sampled at edge k: `CTO` = `CTI` (or `Ld_Err` = 1) after edge k.
- A step at edge k: new `CTO` is visible after edge k. `Min_Tick` (and `Day_Roll` on a 23:59 → 00:00 step) is high for exactly the cycle following edge k, coincident with the new value.
- First step after reset with `EN_CT` held high occurs at edge PRESCALE.
- `EN_CT` deasserted mid-count: the prescaler holds its value and resumes without loss.
- `Clr` mid-count: the next step is again PRESCALE enabled cycles away.
- `LD_CT` and step in the same cycle: the load wins; the step is lost.

## Configuration
- `TKP_SECONDS_EN` defined:
  - A step advances `Sec_O` 0..59.
  - A minute advance occurs on the step where `Sec_O` wraps 59 → 0.
  - A minute takes 60×PRESCALE enabled cycles.
  - `Inc_Min` and `Inc_Hr` do not affect `Sec_O`.
- `TKP_SECONDS_EN` undefined:
  - No seconds register is built; `Sec_O` is tied to 0.
  - Each step advances the minute directly.

## Test plan
- **Reset and first tick** (PRESCALE=4, no macro): `Clr` 1 cycle, then `EN_CT`=1 → `CTO`=0x0000 for 4 cycles, then `CTO`=0x0001 with a single-cycle `Min_Tick`.
- **Week rollover:** load `CTI`=0x6BD9 (day 6, 23:59), `DAYS`=7 → after the next step `CTO`=0x0000, `Min_Tick`=1 and `Day_Roll`=1 for one cycle.
- **Illegal load:** `CTO`=0x0123, load 0x000A → `Ld_Err` pulses once, `CTO` stays 0x0123. Repeat with hours=24 (0x0C00) and with day=7 (0x7000); each is rejected the same way.
- **Adjust:**
  - At 00:59 (0x0059), `Inc_Min` → 0x0000, no `Min_Tick`.
  - At 23:xx, `Inc_Hr` → hours 0, day unchanged, no `Day_Roll`.
  - `Inc_Min` coincident with a prescaler wrap → exactly +1 minute.
- **Hold and priority:**
  - `EN_CT`=0 for 10 cycles mid-count → `CTO` and prescaler unchanged; the step resumes at the correct remaining count.
  - `Clr` and `LD_CT` together → `CTO`=0, `Ld_Err`=0.
- **Seconds** (`TKP_SECONDS_EN`, PRESCALE=2):
  - `Sec_O` increments every 2 cycles; the minute advances at cycle 120 as `Sec_O` goes 59 → 0.
  - A load at `Sec_O`=37 → `Sec_O`=0.

Source files
------------

// File: rtl/time_keeper_param.sv
// time_keeper_param: BCD minutes, binary hours and day-of-week time keeper
// with a PRESCALE-cycle step prescaler, validated load, carry-free set-mode
// adjust, and one-cycle Min_Tick / Day_Roll / Ld_Err pulses.
// Optional macro TKP_SECONDS_EN adds a 0..59 seconds register between the
// step and the minute advance. Without it, Sec_O is tied to 0.
module time_keeper_param #(
  parameter int unsigned PRESCALE = 1,
  parameter int unsigned DAYS     = 7
) (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        EN_CT,
  input  logic        LD_CT,
  input  logic [14:0] CTI,
  input  logic        Inc_Min,
  input  logic        Inc_Hr,
  output logic [14:0] CTO,
  output logic [5:0]  Sec_O,
  output logic        Min_Tick,
  output logic        Day_Roll,
  output logic        Ld_Err
);

  localparam int unsigned PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam logic [2:0]    DMAX = 3'(DAYS - 1);

  logic [3:0]    ones_q, ones_d;
  logic [2:0]    tens_q, tens_d;
  logic [4:0]    hrs_q, hrs_d;
  logic [2:0]    day_q, day_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          min_tick_q, min_tick_d;
  logic          day_roll_q, day_roll_d;
  logic          ld_err_q, ld_err_d;
  logic          cti_ok;
  logic          wrap;
  logic          step;
  logic          adv_min;

`ifdef TKP_SECONDS_EN
  logic [5:0]    sec_q, sec_d;
`endif

  assign cti_ok = (CTI[3:0] <= 4'd9) && (CTI[6:4] <= 3'd5) &&
                  (CTI[11:7] <= 5'd23) && ({1'b0, CTI[14:12]} < 4'(DAYS));

  // Next-state: reset handled in the register; load > adjust > counting here.
  // An adjust cycle still advances the prescaler, but its step is dropped.
  always_comb begin
    ones_d     = ones_q;
    tens_d     = tens_q;
    hrs_d      = hrs_q;
    day_d      = day_q;
    presc_d    = presc_q;
    min_tick_d = 1'b0;
    day_roll_d = 1'b0;
    ld_err_d   = 1'b0;
    adv_min    = 1'b0;
`ifdef TKP_SECONDS_EN
    sec_d      = sec_q;
`endif
    wrap = (presc_q == PMAX);
    step = EN_CT && wrap;

    if (LD_CT) begin
      if (cti_ok) begin
        ones_d  = CTI[3:0];
        tens_d  = CTI[6:4];
        hrs_d   = CTI[11:7];
        day_d   = CTI[14:12];
        presc_d = '0;
`ifdef TKP_SECONDS_EN
        sec_d   = '0;
`endif
      end else begin
        ld_err_d = 1'b1;
      end
    end else begin
      if (EN_CT) begin
        presc_d = wrap ? '0 : presc_q + 1'b1;
      end

      if (Inc_Min || Inc_Hr) begin
        if (Inc_Min) begin
          if (ones_q == 4'd9) begin
            ones_d = '0;
            tens_d = (tens_q == 3'd5) ? '0 : tens_q + 1'b1;
          end else begin
            ones_d = ones_q + 1'b1;
          end
        end
        if (Inc_Hr) begin
          hrs_d = (hrs_q == 5'd23) ? '0 : hrs_q + 1'b1;
        end
      end else if (step) begin
`ifdef TKP_SECONDS_EN
        if (sec_q == 6'd59) begin
          sec_d   = '0;
          adv_min = 1'b1;
        end else begin
          sec_d   = sec_q + 1'b1;
        end
`else
        adv_min = 1'b1;
`endif
        if (adv_min) begin
          min_tick_d = 1'b1;
          if (ones_q == 4'd9) begin
            ones_d = '0;
            if (tens_q == 3'd5) begin
              tens_d = '0;
              if (hrs_q == 5'd23) begin
                hrs_d      = '0;
                day_roll_d = 1'b1;
                day_d      = (day_q == DMAX) ? '0 : day_q + 1'b1;
              end else begin
                hrs_d = hrs_q + 1'b1;
              end
            end else begin
              tens_d = tens_q + 1'b1;
            end
          end else begin
            ones_d = ones_q + 1'b1;
          end
        end
      end
    end
  end

  // State register with synchronous clear overriding everything.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      ones_q     <= '0;
      tens_q     <= '0;
      hrs_q      <= '0;
      day_q      <= '0;
      presc_q    <= '0;
      min_tick_q <= 1'b0;
      day_roll_q <= 1'b0;
      ld_err_q   <= 1'b0;
    end else begin
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      hrs_q      <= hrs_d;
      day_q      <= day_d;
      presc_q    <= presc_d;
      min_tick_q <= min_tick_d;
      day_roll_q <= day_roll_d;
      ld_err_q   <= ld_err_d;
    end
  end

`ifdef TKP_SECONDS_EN
  // Seconds register, cleared with the rest of the time value.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      sec_q <= '0;
    end else begin
      sec_q <= sec_d;
    end
  end

  assign Sec_O = sec_q;
`else
  assign Sec_O = '0;
`endif

  assign CTO      = {day_q, hrs_q, tens_q, ones_q};
  assign Min_Tick = min_tick_q;
  assign Day_Roll = day_roll_q;
  assign Ld_Err   = ld_err_q;

endmodule

// File: tb/tb_time_keeper_param.sv
// Testbench for time_keeper_param. Expected observations are queued as each
// stimulus cycle is driven and popped/compared #1 after the following edge.
// Builds with PRESCALE=4 by default, PRESCALE=2 when TKP_SECONDS_EN is set.
module tb_time_keeper_param;

`ifdef TKP_SECONDS_EN
  localparam int unsigned PRESCALE = 2;
`else
  localparam int unsigned PRESCALE = 4;
`endif
  localparam int unsigned DAYS = 7;

  logic        Clk = 1'b0;
  logic        Clr = 1'b0;
  logic        EN_CT = 1'b0;
  logic        LD_CT = 1'b0;
  logic [14:0] CTI = '0;
  logic        Inc_Min = 1'b0;
  logic        Inc_Hr = 1'b0;
  logic [14:0] CTO;
  logic [5:0]  Sec_O;
  logic        Min_Tick;
  logic        Day_Roll;
  logic        Ld_Err;

  time_keeper_param #(.PRESCALE(PRESCALE), .DAYS(DAYS)) dut (
    .Clk(Clk), .Clr(Clr), .EN_CT(EN_CT), .LD_CT(LD_CT), .CTI(CTI),
    .Inc_Min(Inc_Min), .Inc_Hr(Inc_Hr), .CTO(CTO), .Sec_O(Sec_O),
    .Min_Tick(Min_Tick), .Day_Roll(Day_Roll), .Ld_Err(Ld_Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic clr; logic en; logic ld; logic [14:0] cti; logic im; logic ih;
  } stim_t;

  typedef struct packed {
    logic [14:0] cto; logic tick; logic roll; logic err; logic [5:0] sec;
  } obs_t;

  obs_t exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic stim_t st(input logic clr, input logic en, input logic ld,
                               input logic [14:0] cti, input logic im, input logic ih);
    stim_t s;
    s = '{clr: clr, en: en, ld: ld, cti: cti, im: im, ih: ih};
    return s;
  endfunction

  function automatic obs_t ob(input logic [14:0] cto, input logic tick, input logic roll,
                              input logic err, input logic [5:0] sec);
    obs_t o;
    o = '{cto: cto, tick: tick, roll: roll, err: err, sec: sec};
    return o;
  endfunction

  task automatic test_reset();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(st(1, 1, 1, 15'h0123, 1, 1)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    s.push_back(st(1, 0, 1, 15'h000A, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    foreach (s[i]) begin
      {Clr, EN_CT, LD_CT, CTI, Inc_Min, Inc_Hr} = s[i];
      exp_q.push_back(e[i]);
      @(posedge Clk); #1;
      got  = {CTO, Min_Tick, Day_Roll, Ld_Err, Sec_O};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL reset[%0d]: got cto=%h t/r/e=%b%b%b sec=%0d, want cto=%h t/r/e=%b%b%b sec=%0d",
                 i, got.cto, got.tick, got.roll, got.err, got.sec,
                 want.cto, want.tick, want.roll, want.err, want.sec);
      end
    end
  endtask

  task automatic test_illegal_load();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(st(0, 0, 1, 15'h0123, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h000A, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 1, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h0060, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 1, 0));
    s.push_back(st(0, 0, 1, 15'h0C00, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 1, 0));
    s.push_back(st(0, 0, 1, 15'h7000, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 1, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h6BD9, 0, 0)); e.push_back(ob(15'h6BD9, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h0123, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 0, 0));
    foreach (s[i]) begin
      {Clr, EN_CT, LD_CT, CTI, Inc_Min, Inc_Hr} = s[i];
      exp_q.push_back(e[i]);
      @(posedge Clk); #1;
      got  = {CTO, Min_Tick, Day_Roll, Ld_Err, Sec_O};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL illegal_load[%0d]: got cto=%h t/r/e=%b%b%b sec=%0d, want cto=%h t/r/e=%b%b%b sec=%0d",
                 i, got.cto, got.tick, got.roll, got.err, got.sec,
                 want.cto, want.tick, want.roll, want.err, want.sec);
      end
    end
  endtask

  task automatic test_adjust();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(st(0, 0, 1, 15'h0059, 0, 0)); e.push_back(ob(15'h0059, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 1, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h0009, 0, 0)); e.push_back(ob(15'h0009, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 1, 0)); e.push_back(ob(15'h0010, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h3BA3, 0, 0)); e.push_back(ob(15'h3BA3, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 0, 1)); e.push_back(ob(15'h3023, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h0080, 0, 0)); e.push_back(ob(15'h0080, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 0, 1)); e.push_back(ob(15'h0100, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h5BD9, 0, 0)); e.push_back(ob(15'h5BD9, 0, 0, 0, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 1, 1)); e.push_back(ob(15'h5000, 0, 0, 0, 0));
    s.push_back(st(0, 0, 1, 15'h0123, 1, 1)); e.push_back(ob(15'h0123, 0, 0, 0, 0));
    foreach (s[i]) begin
      {Clr, EN_CT, LD_CT, CTI, Inc_Min, Inc_Hr} = s[i];
      exp_q.push_back(e[i]);
      @(posedge Clk); #1;
      got  = {CTO, Min_Tick, Day_Roll, Ld_Err, Sec_O};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL adjust[%0d]: got cto=%h t/r/e=%b%b%b sec=%0d, want cto=%h t/r/e=%b%b%b sec=%0d",
                 i, got.cto, got.tick, got.roll, got.err, got.sec,
                 want.cto, want.tick, want.roll, want.err, want.sec);
      end
    end
  endtask

`ifndef TKP_SECONDS_EN
  task automatic test_first_tick();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(st(1, 0, 0, 15'h0000, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    for (int unsigned k = 1; k < PRESCALE; k++) begin
      s.push_back(st(0, 1, 0, 15'h0000, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    end
    s.push_back(st(0, 1, 0, 15'h0000, 0, 0)); e.push_back(ob(15'h0001, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 15'h0000, 0, 0)); e.push_back(ob(15'h0001, 0, 0, 0, 0));
    foreach (s[i]) begin
      {Clr, EN_CT, LD_CT, CTI, Inc_Min, Inc_Hr} = s[i];
      exp_q.push_back(e[i]);
      @(posedge Clk); #1;
      got  = {CTO, Min_Tick, Day_Roll, Ld_Err, Sec_O};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL first_tick[%0d]: got cto=%h t/r/e=%b%b%b sec=%0d, want cto=%h t/r/e=%b%b%b sec=%0d",
                 i, got.cto, got.tick, got.roll, got.err, got.sec,
                 want.cto, want.tick, want.roll, want.err, want.sec);
      end
    end
  endtask

  task automatic test_rollover();
    logic [14:0] from_v[5] = '{15'h0009, 15'h0059, 15'h0B59, 15'h6BD9, 15'h2BD9};
    logic [14:0] to_v[5]   = '{15'h0010, 15'h0080, 15'h0B80, 15'h0000, 15'h3000};
    logic        roll_v[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    for (int unsigned r = 0; r < 5; r++) begin
      s.push_back(st(0, 0, 1, from_v[r], 0, 0)); e.push_back(ob(from_v[r], 0, 0, 0, 0));
      for (int unsigned k = 1; k < PRESCALE; k++) begin
        s.push_back(st(0, 1, 0, 15'h0000, 0, 0)); e.push_back(ob(from_v[r], 0, 0, 0, 0));
      end
      s.push_back(st(0, 1, 0, 15'h0000, 0, 0)); e.push_back(ob(to_v[r], 1, roll_v[r], 0, 0));
      s.push_back(st(0, 0, 0, 15'h0000, 0, 0)); e.push_back(ob(to_v[r], 0, 0, 0, 0));
    end
    foreach (s[i]) begin
      {Clr, EN_CT, LD_CT, CTI, Inc_Min, Inc_Hr} = s[i];
      exp_q.push_back(e[i]);
      @(posedge Clk); #1;
      got  = {CTO, Min_Tick, Day_Roll, Ld_Err, Sec_O};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL rollover[%0d]: got cto=%h t/r/e=%b%b%b sec=%0d, want cto=%h t/r/e=%b%b%b sec=%0d",
                 i, got.cto, got.tick, got.roll, got.err, got.sec,
                 want.cto, want.tick, want.roll, want.err, want.sec);
      end
    end
  endtask

  // PRESCALE=4 assumed: stimulus counts prescaler phases explicitly.
  task automatic test_hold_priority();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(st(0, 0, 1, 15'h0000, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    repeat (2) begin s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0)); end
    repeat (10) begin s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0)); end
    s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0001, 1, 0, 0, 0));
    repeat (2) begin s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0001, 0, 0, 0, 0)); end
    s.push_back(st(1, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    repeat (3) begin s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0)); end
    s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0001, 1, 0, 0, 0));
    repeat (3) begin s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0001, 0, 0, 0, 0)); end
    s.push_back(st(0, 1, 1, 15'h0123, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 0, 0));
    repeat (3) begin s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 0, 0)); end
    s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0124, 1, 0, 0, 0));
    repeat (3) begin s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0124, 0, 0, 0, 0)); end
    s.push_back(st(0, 1, 0, 0, 1, 0)); e.push_back(ob(15'h0125, 0, 0, 0, 0));
    repeat (3) begin s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0125, 0, 0, 0, 0)); end
    s.push_back(st(0, 1, 0, 0, 0, 0)); e.push_back(ob(15'h0126, 1, 0, 0, 0));
    s.push_back(st(0, 0, 0, 0, 0, 0)); e.push_back(ob(15'h0126, 0, 0, 0, 0));
    foreach (s[i]) begin
      {Clr, EN_CT, LD_CT, CTI, Inc_Min, Inc_Hr} = s[i];
      exp_q.push_back(e[i]);
      @(posedge Clk); #1;
      got  = {CTO, Min_Tick, Day_Roll, Ld_Err, Sec_O};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL hold_priority[%0d]: got cto=%h t/r/e=%b%b%b sec=%0d, want cto=%h t/r/e=%b%b%b sec=%0d",
                 i, got.cto, got.tick, got.roll, got.err, got.sec,
                 want.cto, want.tick, want.roll, want.err, want.sec);
      end
    end
  endtask
`else
  // PRESCALE=2: seconds advance every 2 enabled edges; minute at edge 120.
  task automatic test_seconds();
    stim_t s[$];
    obs_t  e[$];
    obs_t  got, want;
    s.push_back(st(1, 0, 0, 15'h0000, 0, 0)); e.push_back(ob(15'h0000, 0, 0, 0, 0));
    for (int unsigned k = 1; k <= 194; k++) begin
      s.push_back(st(0, 1, 0, 0, 0, 0));
      e.push_back(ob((k >= 120) ? 15'h0001 : 15'h0000, (k == 120), 1'b0, 1'b0,
                     6'((k / 2) % 60)));
    end
    s.push_back(st(0, 1, 1, 15'h0123, 0, 0)); e.push_back(ob(15'h0123, 0, 0, 0, 0));
    s.push_back(st(0, 1, 0, 0, 0, 0));        e.push_back(ob(15'h0123, 0, 0, 0, 0));
    s.push_back(st(0, 1, 0, 0, 0, 0));        e.push_back(ob(15'h0123, 0, 0, 0, 1));
    s.push_back(st(0, 0, 0, 0, 1, 1));        e.push_back(ob(15'h01A4, 0, 0, 0, 1));
    foreach (s[i]) begin
      {Clr, EN_CT, LD_CT, CTI, Inc_Min, Inc_Hr} = s[i];
      exp_q.push_back(e[i]);
      @(posedge Clk); #1;
      got  = {CTO, Min_Tick, Day_Roll, Ld_Err, Sec_O};
      want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL seconds[%0d]: got cto=%h t/r/e=%b%b%b sec=%0d, want cto=%h t/r/e=%b%b%b sec=%0d",
                 i, got.cto, got.tick, got.roll, got.err, got.sec,
                 want.cto, want.tick, want.roll, want.err, want.sec);
      end
    end
  endtask
`endif

  initial begin
    @(posedge Clk); #1;
    test_reset();
    test_illegal_load();
    test_adjust();
`ifndef TKP_SECONDS_EN
    test_first_tick();
    test_rollover();
    test_hold_priority();
`else
    test_seconds();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
